// File: rtl/tetris_pkg.sv
// Shared playfield defaults, controller state encoding and line-clear score table.
package tetris_pkg;

   localparam int ROWS_DEF = 20;
   localparam int COLS_DEF = 10;
   localparam int PW_DEF   = 4;
   localparam int RW       = 5;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      STAMP = 3'd1,
      SCAN  = 3'd2,
      SHIFT = 3'd3,
      DONE  = 3'd4
   } lc_state_t;

   typedef logic [COLS_DEF-1:0] row_t;

   localparam logic [19:0] LINE_SCORE [0:4] = '{20'd0, 20'd40, 20'd100, 20'd300, 20'd1200};
   localparam logic [19:0] SCORE_MAX = 20'd999999;

   // More than four lines cannot clear at once; anything else scores nothing.
   function automatic logic [19:0] line_score(input logic [2:0] cnt);
      case (cnt)
         3'd1:    return LINE_SCORE[1];
         3'd2:    return LINE_SCORE[2];
         3'd3:    return LINE_SCORE[3];
         3'd4:    return LINE_SCORE[4];
         default: return LINE_SCORE[0];
      endcase
   endfunction

endpackage

// File: rtl/grid_rowfile.sv
// Playfield storage: ROWS-1 writable rows plus a constant all-ones floor row.
// Ports: one render read, one scan read, one row copy/clear write, one 4-row OR stamp.
module grid_rowfile
   import tetris_pkg::*;
#(
   parameter int ROWS = ROWS_DEF,
   parameter int COLS = COLS_DEF,
   parameter int PW   = PW_DEF
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic [RW-1:0]            i_rd_row,
   output logic [COLS-1:0]          o_rd_data,
   input  logic [RW-1:0]            i_scan_row,
   output logic                     o_scan_full,
   output logic                     o_scan_any,
   input  logic                     i_mv_en,
   input  logic                     i_mv_clr,
   input  logic [RW-1:0]            i_mv_row,
   input  logic                     i_stamp_en,
   input  logic [RW-1:0]            i_stamp_row,
   input  logic [PW-1:0][COLS-1:0]  i_stamp_bits
);

   logic [ROWS-2:0][COLS-1:0] r_rows;
   logic [ROWS-2:0][COLS-1:0] w_or;
   logic [COLS-1:0]           w_scan;

   function automatic logic [COLS-1:0] row_at(input logic [RW-1:0] idx,
                                               input logic [ROWS-2:0][COLS-1:0] rows);
      if (idx == RW'(ROWS-1))
         return '1;
      else if (idx < RW'(ROWS-1))
         return rows[idx];
      else
         return '0;
   endfunction

   assign o_rd_data   = row_at(i_rd_row, r_rows);
   assign w_scan      = row_at(i_scan_row, r_rows);
   assign o_scan_full = &w_scan;
   assign o_scan_any  = |w_scan;

   // Stamp rows at or below the floor never match a writable row, so they drop out here.
   always_comb begin
      w_or = '0;
      for (int r = 0; r < ROWS-1; r++) begin
         for (int i = 0; i < PW; i++) begin
            if (({1'b0, i_stamp_row} + (RW+1)'(i)) == (RW+1)'(r))
               w_or[r] = w_or[r] | i_stamp_bits[i];
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rows <= '0;
      end else if (i_stamp_en) begin
         for (int r = 0; r < ROWS-1; r++)
            r_rows[r] <= r_rows[r] | w_or[r];
      end else if (i_mv_en) begin
         if (i_mv_clr) begin
            for (int r = 0; r < ROWS-1; r++)
               if (i_mv_row == RW'(r)) r_rows[r] <= '0;
         end else begin
            for (int r = 1; r < ROWS-1; r++)
               if (i_mv_row == RW'(r)) r_rows[r] <= r_rows[r-1];
         end
      end
   end

endmodule

// File: rtl/line_clear_ctrl.sv
// Lock/scan/shift/report sequencer around the playfield row file.
// Optional feature macro: SCORE_EN enables the saturating score accumulator.
module line_clear_ctrl
   import tetris_pkg::*;
#(
   parameter int ROWS = ROWS_DEF,
   parameter int COLS = COLS_DEF,
   parameter int PW   = PW_DEF
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              lock_req,
   output logic              lock_ack,
   input  logic [4:0]        lock_row,
   input  logic [3:0]        lock_col,
   input  logic [PW*PW-1:0]  lock_mask,
   output logic              busy,
   output logic              clear_done,
   output logic [2:0]        lines_cleared,
   output logic [15:0]       total_lines,
   output logic              game_over,
   output logic [19:0]       score,
   input  logic [4:0]        rd_row,
   output logic [COLS-1:0]   rd_data,
   output logic [2:0]        dbg_state
);

   // lock_req/lock_ack: the request and its row/col/mask stay stable until the
   // cycle lock_ack is high; the stamp is written from those inputs in that cycle.

   lc_state_t r_state, w_next;
   logic [RW-1:0]  r_ptr, r_sh;
   logic [2:0]     r_cnt, r_lines;
   logic           r_lock_ack, r_busy, r_clear_done, r_game_over;
   logic [15:0]    r_total;
   logic [16:0]    w_total_sum;
   logic           w_scan_full, w_scan_any;
   logic           w_stamp_en, w_mv_en, w_mv_clr;
   logic [PW-1:0][COLS-1:0] w_stamp_bits;

   grid_rowfile #(.ROWS(ROWS), .COLS(COLS), .PW(PW)) u_rowfile (
      .i_clk        (Clk),
      .i_rst_n      (Reset_n),
      .i_rd_row     (rd_row),
      .o_rd_data    (rd_data),
      .i_scan_row   (r_ptr),
      .o_scan_full  (w_scan_full),
      .o_scan_any   (w_scan_any),
      .i_mv_en      (w_mv_en),
      .i_mv_clr     (w_mv_clr),
      .i_mv_row     (r_sh),
      .i_stamp_en   (w_stamp_en),
      .i_stamp_row  (lock_row),
      .i_stamp_bits (w_stamp_bits)
   );

   // Box column j lands on playfield column lock_col+j; column 0 is the row MSB.
   always_comb begin
      w_stamp_bits = '0;
      for (int i = 0; i < PW; i++)
         for (int j = 0; j < PW; j++)
            for (int k = 0; k < COLS; k++)
               if ((int'(lock_col) + j == k) && lock_mask[(PW-1-i)*PW + (PW-1-j)])
                  w_stamp_bits[i][COLS-1-k] = 1'b1;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (lock_req) w_next = STAMP;
         STAMP:   w_next = SCAN;
         SCAN:    if (w_scan_full) w_next = SHIFT;
                  else if (r_ptr == '0) w_next = DONE;
         SHIFT:   if (r_sh == '0) w_next = SCAN;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   assign w_stamp_en  = (r_state == STAMP);
   assign w_mv_en     = (r_state == SHIFT);
   assign w_mv_clr    = (r_sh == '0);
   assign w_total_sum = {1'b0, r_total} + 17'(r_cnt);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_ptr        <= '0;
         r_sh         <= '0;
         r_cnt        <= '0;
         r_lines      <= '0;
         r_lock_ack   <= 1'b0;
         r_busy       <= 1'b0;
         r_clear_done <= 1'b0;
         r_total      <= '0;
         r_game_over  <= 1'b0;
      end else begin
         r_lock_ack   <= (w_next == STAMP);
         r_busy       <= (w_next != IDLE);
         r_clear_done <= (w_next == DONE);
         if (w_next == DONE) r_lines <= r_cnt;
         case (r_state)
            STAMP: begin
               r_ptr <= RW'(ROWS-2);
               r_cnt <= '0;
            end
            SCAN: begin
               if (w_scan_full) begin
                  r_cnt <= r_cnt + 3'd1;
                  r_sh  <= r_ptr;
               end else if (r_ptr != '0) begin
                  r_ptr <= r_ptr - RW'(1);
               end
            end
            SHIFT: if (r_sh != '0) r_sh <= r_sh - RW'(1);
            DONE: begin
               // r_ptr is 0 here, so the scan port is looking at the top row.
               r_total     <= w_total_sum[16] ? 16'hFFFF : w_total_sum[15:0];
               r_game_over <= r_game_over | w_scan_any;
            end
            default: ;
         endcase
      end
   end

`ifdef SCORE_EN
   logic [19:0] r_score;
   logic [20:0] w_score_sum;

   assign w_score_sum = {1'b0, r_score} + {1'b0, line_score(r_cnt)};

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)
         r_score <= '0;
      else if (r_state == DONE)
         r_score <= (w_score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : w_score_sum[19:0];
   end

   assign score = r_score;
`else
   assign score = 20'd0;
`endif

   assign lock_ack      = r_lock_ack;
   assign busy          = r_busy;
   assign clear_done    = r_clear_done;
   assign lines_cleared = r_lines;
   assign total_lines   = r_total;
   assign game_over     = r_game_over;
   assign dbg_state     = r_state;

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Directed bench for line_clear_ctrl: lock vector table plus queued-request and mid-shift reset sequences.
module tb_line_clear_ctrl;
  import tetris_pkg::*;

  logic        Clk, Reset_n, lock_req, lock_ack;
  logic [4:0]  lock_row, rd_row;
  logic [3:0]  lock_col;
  logic [15:0] lock_mask, total_lines;
  logic        busy, clear_done, game_over;
  logic [2:0]  lines_cleared, dbg_state;
  logic [19:0] score;
  logic [9:0]  rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  line_clear_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .lock_req(lock_req), .lock_ack(lock_ack),
    .lock_row(lock_row), .lock_col(lock_col), .lock_mask(lock_mask), .busy(busy),
    .clear_done(clear_done), .lines_cleared(lines_cleared), .total_lines(total_lines),
    .game_over(game_over), .score(score), .rd_row(rd_row), .rd_data(rd_data),
    .dbg_state(dbg_state)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_row(input string name, input logic [4:0] r, input logic [9:0] exp);
    rd_row = r;
    #1;
    check(name, 32'(rd_data), 32'(exp));
  endtask

  task automatic do_reset();
    lock_req = 1'b0;
    Reset_n  = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
  endtask

  // Drive one lock; returns ack seen, cycles from ack to clear_done, and lines_cleared then.
  task automatic do_lock(input logic [4:0] r, input logic [3:0] c, input logic [15:0] m,
                         output bit ok, output int lat, output logic [2:0] lines);
    lock_row  = r;
    lock_col  = c;
    lock_mask = m;
    lock_req  = 1'b1;
    ok    = 1'b0;
    lat   = -1;
    lines = '0;
    for (int n = 0; n < 50; n++) begin
      @(negedge Clk);
      if (lock_ack) begin ok = 1'b1; break; end
    end
    lock_req = 1'b0;
    if (ok) begin
      for (int n = 1; n < 300; n++) begin
        @(negedge Clk);
        if (clear_done) begin lat = n; lines = lines_cleared; break; end
      end
    end
  endtask

  typedef struct {
    bit          rst;
    logic [4:0]  row;
    logic [3:0]  col;
    logic [15:0] mask;
    logic [2:0]  exp_lines;
    int          exp_lat;
    logic [4:0]  r1;
    logic [9:0]  d1;
    logic [4:0]  r2;
    logic [9:0]  d2;
    logic [15:0] exp_total;
    logic [19:0] exp_score;
    bit          exp_go;
  } vec_t;

  vec_t vecs[11];

  initial begin
    bit ok;
    int lat, cd_at, ack2_at, seen;
    logic [2:0] lines;

    vecs[0]  = '{1, 5'd17, 4'd0, 16'h6600, 3'd0,  20, 5'd17, 10'h180, 5'd18, 10'h180, 16'd0, 20'd0,    0};
    vecs[1]  = '{1, 5'd17, 4'd0, 16'h5F00, 3'd0,  20, 5'd17, 10'h140, 5'd18, 10'h3C0, 16'd0, 20'd0,    0};
    vecs[2]  = '{0, 5'd17, 4'd4, 16'h5C00, 3'd0,  20, 5'd17, 10'h154, 5'd18, 10'h3F0, 16'd0, 20'd0,    0};
    vecs[3]  = '{0, 5'd17, 4'd8, 16'h4000, 3'd0,  20, 5'd17, 10'h155, 5'd18, 10'h3F0, 16'd0, 20'd0,    0};
    vecs[4]  = '{0, 5'd18, 4'd6, 16'hF000, 3'd1,  40, 5'd18, 10'h155, 5'd0,  10'h000, 16'd1, 20'd40,   0};
    vecs[5]  = '{1, 5'd15, 4'd0, 16'hFFFF, 3'd0,  20, 5'd15, 10'h3C0, 5'd18, 10'h3C0, 16'd0, 20'd0,    0};
    vecs[6]  = '{0, 5'd15, 4'd4, 16'hFFFF, 3'd0,  20, 5'd16, 10'h3FC, 5'd17, 10'h3FC, 16'd0, 20'd0,    0};
    vecs[7]  = '{0, 5'd15, 4'd8, 16'h8888, 3'd0,  20, 5'd15, 10'h3FE, 5'd18, 10'h3FE, 16'd0, 20'd0,    0};
    vecs[8]  = '{0, 5'd15, 4'd6, 16'h1111, 3'd4, 100, 5'd15, 10'h000, 5'd18, 10'h000, 16'd4, 20'd1200, 0};
    vecs[9]  = '{1, 5'd18, 4'd8, 16'hFFFF, 3'd0,  20, 5'd18, 10'h003, 5'd19, 10'h3FF, 16'd0, 20'd0,    0};
    vecs[10] = '{0, 5'd0,  4'd0, 16'h8000, 3'd0,  20, 5'd0,  10'h200, 5'd25, 10'h000, 16'd0, 20'd0,    1};

    Reset_n = 1'b0; lock_req = 1'b0; lock_row = '0; lock_col = '0; lock_mask = '0; rd_row = '0;

    // Reset state
    do_reset();
    check_row("rst_floor", 5'd19, 10'h3FF);
    check_row("rst_row0", 5'd0, 10'h000);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_score", 32'(score), 32'd0);
    check("rst_ack", 32'(lock_ack), 32'd0);
    check("rst_done", 32'(clear_done), 32'd0);
    check("rst_total", 32'(total_lines), 32'd0);
    check("rst_go", 32'(game_over), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));

    // Lock vector table
    for (int k = 0; k < 11; k++) begin
      if (vecs[k].rst) do_reset();
      do_lock(vecs[k].row, vecs[k].col, vecs[k].mask, ok, lat, lines);
      check($sformatf("v%0d_ack", k), 32'(ok), 32'd1);
      check($sformatf("v%0d_latency", k), 32'(lat), 32'(vecs[k].exp_lat));
      check($sformatf("v%0d_lines", k), 32'(lines), 32'(vecs[k].exp_lines));
      @(negedge Clk);
      check($sformatf("v%0d_busy", k), 32'(busy), 32'd0);
      check($sformatf("v%0d_total", k), 32'(total_lines), 32'(vecs[k].exp_total));
`ifdef SCORE_EN
      check($sformatf("v%0d_score", k), 32'(score), 32'(vecs[k].exp_score));
`else
      check($sformatf("v%0d_score", k), 32'(score), 32'd0);
`endif
      check($sformatf("v%0d_game_over", k), 32'(game_over), 32'(vecs[k].exp_go));
      check_row($sformatf("v%0d_row%0d", k, vecs[k].r1), vecs[k].r1, vecs[k].d1);
      check_row($sformatf("v%0d_row%0d", k, vecs[k].r2), vecs[k].r2, vecs[k].d2);
    end

    // Request held through a running sequence is queued, not dropped
    do_reset();
    lock_row = 5'd17; lock_col = 4'd0; lock_mask = 16'h6600; lock_req = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge Clk);
      if (lock_ack) begin ok = 1'b1; break; end
    end
    check("held_ack1", 32'(ok), 32'd1);
    cd_at = -1; ack2_at = -1;
    for (int n = 1; n < 100; n++) begin
      @(negedge Clk);
      if (clear_done && cd_at < 0) cd_at = n;
      if (lock_ack) begin ack2_at = n; break; end
    end
    lock_req = 1'b0;
    check("held_done1_cycle", 32'(cd_at), 32'd20);
    check("held_ack2_cycle", 32'(ack2_at), 32'd22);
    lat = -1;
    for (int n = 1; n < 300; n++) begin
      @(negedge Clk);
      if (clear_done) begin lat = n; lines = lines_cleared; break; end
    end
    check("held_done2_cycle", 32'(lat), 32'd20);
    check("held_lines2", 32'(lines), 32'd0);
    check_row("held_row17", 5'd17, 10'h180);

    // Reset asserted in the middle of SHIFT
    do_reset();
    do_lock(5'd18, 4'd0, 16'hFFFF, ok, lat, lines);
    do_lock(5'd18, 4'd4, 16'hFFFF, ok, lat, lines);
    check_row("mid_pre_row18", 5'd18, 10'h3FC);
    lock_row = 5'd18; lock_col = 4'd8; lock_mask = 16'hFFFF; lock_req = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge Clk);
      if (lock_ack) begin ok = 1'b1; break; end
    end
    lock_req = 1'b0;
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge Clk);
      if (dbg_state == 3'(SHIFT)) begin seen = 1; break; end
    end
    check("mid_reached_shift", 32'(seen), 32'd1);
    repeat (3) @(negedge Clk);
    Reset_n = 1'b0;
    check_row("mid_row18", 5'd18, 10'h000);
    check_row("mid_row17", 5'd17, 10'h000);
    check_row("mid_floor", 5'd19, 10'h3FF);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_state", 32'(dbg_state), 32'(IDLE));
    @(negedge Clk);
    Reset_n = 1'b1;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge Clk);
      if (clear_done) seen++;
    end
    check("mid_no_done", 32'(seen), 32'd0);
    check("mid_total", 32'(total_lines), 32'd0);
    check("mid_go", 32'(game_over), 32'd0);
    check("mid_lines", 32'(lines_cleared), 32'd0);
    check("mid_score", 32'(score), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
